// File: rtl/ibex_register_file_fpga_mp.sv
// Multi-port FPGA register file: NumRead async read ports, two write ports.
// Storage is two single-writer RAM banks; a flop-based live value table (LVT)
// records which bank holds the most recent value of each word. After reset an
// init sweep loads WordZeroVal into both banks, since FPGA RAMs have no reset.
module ibex_register_file_fpga_mp #(
  parameter bit                   RV32E       = 1'b0,
  parameter int unsigned          DataWidth   = 32,
  parameter int unsigned          NumRead     = 2,
  parameter bit                   WriteBypass = 1'b0,
  parameter bit                   WrenCheck   = 1'b0,
  parameter logic [DataWidth-1:0] WordZeroVal = '0
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              test_en_i,
  input  logic [NumRead-1:0][4:0]           raddr_i,
  output logic [NumRead-1:0][DataWidth-1:0] rdata_o,
  input  logic [1:0][4:0]                   waddr_i,
  input  logic [1:0][DataWidth-1:0]         wdata_i,
  input  logic [1:0]                        we_i,
  output logic                              ready_o,
  output logic                              err_o
);

  localparam int unsigned AddrWidth = RV32E ? 4 : 5;
  localparam int unsigned NumWords  = 2 ** AddrWidth;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  state_e                 r_state;
  logic [AddrWidth-1:0]   r_cnt;
  logic                   r_ready;
  logic [NumWords-1:0]    r_lvt;
  logic [DataWidth-1:0]   r_bank0 [NumWords];
  logic [DataWidth-1:0]   r_bank1 [NumWords];

  logic                        w_init;
  logic [1:0][AddrWidth-1:0]   w_waddr;
  logic [1:0]                  w_we_eff;
  logic [1:0]                  w_bank_we;
  logic [1:0][AddrWidth-1:0]   w_bank_addr;
  logic [1:0][DataWidth-1:0]   w_bank_wdata;
  logic                        w_unused;

  // Upper address bit (RV32E) and the FPGA-irrelevant test enable are unused.
  assign w_unused = ^{test_en_i, raddr_i, waddr_i};

  assign w_init = (r_state == ST_INIT);

  // Write-side address truncation, effective enables and bank port muxing.
  // During INIT both banks are owned by the sweep; user writes are dropped.
  for (genvar p = 0; p < 2; p++) begin : gen_wr
    assign w_waddr[p]      = waddr_i[p][AddrWidth-1:0];
    assign w_we_eff[p]     = !w_init && we_i[p] && (w_waddr[p] != '0);
    assign w_bank_we[p]    = w_init ? 1'b1 : w_we_eff[p];
    assign w_bank_addr[p]  = w_init ? r_cnt : w_waddr[p];
    assign w_bank_wdata[p] = w_init ? WordZeroVal : wdata_i[p];
  end

  // Init sweep FSM: walk every address once, then stay in RUN until reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == AddrWidth'(NumWords - 1)) begin
            r_state <= ST_RUN;
            r_ready <= 1'b1;
          end
        end
        ST_RUN: begin
          r_state <= ST_RUN;
        end
        default: begin
          r_state <= ST_INIT;
          r_cnt   <= '0;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o = r_ready;

  // Live value table: port 1 is assigned last so it wins a same-address clash.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lvt <= '0;
    end else if (w_init) begin
      r_lvt[r_cnt] <= 1'b0;
    end else begin
      if (w_we_eff[0]) r_lvt[w_waddr[0]] <= 1'b0;
      if (w_we_eff[1]) r_lvt[w_waddr[1]] <= 1'b1;
    end
  end

  // Bank 0: written only by write port 0 (or the init sweep); no reset.
  always_ff @(posedge clk_i) begin
    if (w_bank_we[0]) r_bank0[w_bank_addr[0]] <= w_bank_wdata[0];
  end

  // Bank 1: written only by write port 1 (or the init sweep); no reset.
  always_ff @(posedge clk_i) begin
    if (w_bank_we[1]) r_bank1[w_bank_addr[1]] <= w_bank_wdata[1];
  end

  // Read ports. During INIT the banks may still hold stale or undefined data,
  // so the reset value is returned directly instead of the RAM output.
  for (genvar r = 0; r < NumRead; r++) begin : gen_rd
    logic [AddrWidth-1:0] w_ra;
    logic [DataWidth-1:0] w_rd;

    assign w_ra = raddr_i[r][AddrWidth-1:0];

    // LVT-selected bank read with optional same-cycle forwarding.
    always_comb begin
      w_rd = r_lvt[w_ra] ? r_bank1[w_ra] : r_bank0[w_ra];
      if (WriteBypass) begin
        if (w_we_eff[0] && (w_waddr[0] == w_ra)) w_rd = wdata_i[0];
        if (w_we_eff[1] && (w_waddr[1] == w_ra)) w_rd = wdata_i[1];
      end
      if (w_init)        w_rd = WordZeroVal;
      if (w_ra == '0)    w_rd = '0;
    end

    assign rdata_o[r] = w_rd;
  end

  // Spurious strobe detection: a RUN-mode bank write without its enable.
  assign err_o = WrenCheck && !w_init && |(w_bank_we & ~we_i);

endmodule

// File: tb/tb_ibex_register_file_fpga_mp.sv
// Bench for ibex_register_file_fpga_mp: two instances sharing stimulus.
//   dut_a: 32 words, no bypass, strobe check on, reset value DEADBEEF
//   dut_e: 16 words (RV32E), bypass on, strobe check off, reset value CAFEF00D
module tb_ibex_register_file_fpga_mp;

  localparam logic [31:0] ZA = 32'hDEADBEEF;
  localparam logic [31:0] ZE = 32'hCAFEF00D;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             test_en;
  logic [2:0][4:0]  raddr;
  logic [2:0][31:0] rdata_a, rdata_e;
  logic [1:0][4:0]  waddr;
  logic [1:0][31:0] wdata;
  logic [1:0]       we;
  logic             ready_a, ready_e, err_a, err_e;

  int n_cmp = 0;
  int n_mis = 0;
  logic [31:0] sb[$];
  logic [31:0] m_a [32];
  logic [31:0] m_e [16];

  always #5 clk = ~clk;

  ibex_register_file_fpga_mp #(
    .RV32E(1'b0), .DataWidth(32), .NumRead(3), .WriteBypass(1'b0),
    .WrenCheck(1'b1), .WordZeroVal(ZA)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .test_en_i(test_en), .raddr_i(raddr),
    .rdata_o(rdata_a), .waddr_i(waddr), .wdata_i(wdata), .we_i(we),
    .ready_o(ready_a), .err_o(err_a)
  );

  ibex_register_file_fpga_mp #(
    .RV32E(1'b1), .DataWidth(32), .NumRead(3), .WriteBypass(1'b1),
    .WrenCheck(1'b0), .WordZeroVal(ZE)
  ) dut_e (
    .clk_i(clk), .rst_ni(rst_n), .test_en_i(test_en), .raddr_i(raddr),
    .rdata_o(rdata_e), .waddr_i(waddr), .wdata_i(wdata), .we_i(we),
    .ready_o(ready_e), .err_o(err_e)
  );

  task automatic drv();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int za, ze;
    logic [31:0] e;
    rst_n = 1'b0; we = '0; raddr = '0; waddr = '0; wdata = '0;
    repeat (3) drv();
    raddr[0] = 5'd9; raddr[1] = 5'd0;
    sb.push_back(32'd0); sb.push_back(ZA);
    @(negedge clk);
    e = sb.pop_front();
    n_cmp++; if ({31'd0, ready_a} !== e) begin n_mis++; $display("FAIL reset_ready: got %0d expected %0d", ready_a, e); end
    e = sb.pop_front();
    n_cmp++; if (rdata_a[0] !== e) begin n_mis++; $display("FAIL reset_read9: got %h expected %h", rdata_a[0], e); end
    n_cmp++; if (err_a !== 1'b0) begin n_mis++; $display("FAIL reset_err: got %b expected 0", err_a); end
    drv();
    rst_n = 1'b1;
    za = 0; ze = 0;
    sb.push_back(32); sb.push_back(16);
    for (int i = 0; i < 100 && !(ready_a === 1'b1 && ready_e === 1'b1); i++) begin
      @(negedge clk);
      if (ready_a !== 1'b1) za++;
      if (ready_e !== 1'b1) ze++;
    end
    e = sb.pop_front();
    n_cmp++; if (za !== int'(e)) begin n_mis++; $display("FAIL init_cycles_a: got %0d expected %0d", za, e); end
    e = sb.pop_front();
    n_cmp++; if (ze !== int'(e)) begin n_mis++; $display("FAIL init_cycles_e: got %0d expected %0d", ze, e); end
    sb.push_back(ZA); sb.push_back(32'd0); sb.push_back(ZE); sb.push_back(32'd0);
    @(negedge clk);
    for (int r = 0; r < 2; r++) begin
      e = sb.pop_front();
      n_cmp++; if (rdata_a[r] !== e) begin n_mis++; $display("FAIL swept_a port%0d: got %h expected %h", r, rdata_a[r], e); end
    end
    for (int r = 0; r < 2; r++) begin
      e = sb.pop_front();
      n_cmp++; if (rdata_e[r] !== e) begin n_mis++; $display("FAIL swept_e port%0d: got %h expected %h", r, rdata_e[r], e); end
    end
  endtask

  task automatic test_dual_write();
    logic [31:0] e;
    drv();
    we = 2'b11; waddr[0] = 5'd5; waddr[1] = 5'd5;
    wdata[0] = 32'h11111111; wdata[1] = 32'h22222222; raddr[0] = 5'd5;
    drv();
    we = '0;
    sb.push_back(32'h22222222); sb.push_back(32'h22222222);
    @(negedge clk);
    e = sb.pop_front();
    n_cmp++; if (rdata_a[0] !== e) begin n_mis++; $display("FAIL dual_wr_a: got %h expected %h", rdata_a[0], e); end
    e = sb.pop_front();
    n_cmp++; if (rdata_e[0] !== e) begin n_mis++; $display("FAIL dual_wr_e: got %h expected %h", rdata_e[0], e); end
    drv();
    we = 2'b01; wdata[0] = 32'h33333333;
    drv();
    we = '0; raddr[1] = 5'd21;
    sb.push_back(32'h33333333); sb.push_back(32'h33333333); sb.push_back(ZA); sb.push_back(32'h33333333);
    @(negedge clk);
    e = sb.pop_front();
    n_cmp++; if (rdata_a[0] !== e) begin n_mis++; $display("FAIL port0_after_a: got %h expected %h", rdata_a[0], e); end
    e = sb.pop_front();
    n_cmp++; if (rdata_e[0] !== e) begin n_mis++; $display("FAIL port0_after_e: got %h expected %h", rdata_e[0], e); end
    e = sb.pop_front();
    n_cmp++; if (rdata_a[1] !== e) begin n_mis++; $display("FAIL addr21_a: got %h expected %h", rdata_a[1], e); end
    e = sb.pop_front();
    n_cmp++; if (rdata_e[1] !== e) begin n_mis++; $display("FAIL alias21_e: got %h expected %h", rdata_e[1], e); end
  endtask

  task automatic test_r0_write();
    logic [31:0] e;
    drv();
    we = 2'b01; waddr[0] = 5'd0; wdata[0] = 32'hFFFFFFFF; raddr[0] = 5'd0;
    sb.push_back(32'd0); sb.push_back(32'd0);
    @(negedge clk);
    e = sb.pop_front();
    n_cmp++; if ({30'd0, dut_a.w_bank_we} !== e) begin n_mis++; $display("FAIL r0_strobe: got %b expected %h", dut_a.w_bank_we, e); end
    e = sb.pop_front();
    n_cmp++; if ({31'd0, err_a} !== e) begin n_mis++; $display("FAIL r0_err: got %b expected %h", err_a, e); end
    drv();
    we = '0;
    sb.push_back(32'd0); sb.push_back(32'd0);
    @(negedge clk);
    e = sb.pop_front();
    n_cmp++; if (rdata_a[0] !== e) begin n_mis++; $display("FAIL r0_read_a: got %h expected %h", rdata_a[0], e); end
    e = sb.pop_front();
    n_cmp++; if (rdata_e[0] !== e) begin n_mis++; $display("FAIL r0_read_e: got %h expected %h", rdata_e[0], e); end
  endtask

  task automatic test_bypass();
    logic [31:0] e;
    drv();
    we = 2'b01; waddr[0] = 5'd7; wdata[0] = 32'hA5A5A5A5;
    for (int r = 0; r < 3; r++) raddr[r] = 5'd7;
    for (int r = 0; r < 3; r++) begin sb.push_back(ZA); sb.push_back(32'hA5A5A5A5); end
    @(negedge clk);
    for (int r = 0; r < 3; r++) begin
      e = sb.pop_front();
      n_cmp++; if (rdata_a[r] !== e) begin n_mis++; $display("FAIL nobypass_old port%0d: got %h expected %h", r, rdata_a[r], e); end
      e = sb.pop_front();
      n_cmp++; if (rdata_e[r] !== e) begin n_mis++; $display("FAIL bypass_same port%0d: got %h expected %h", r, rdata_e[r], e); end
    end
    drv();
    we = '0;
    for (int r = 0; r < 3; r++) begin sb.push_back(32'hA5A5A5A5); sb.push_back(32'hA5A5A5A5); end
    @(negedge clk);
    for (int r = 0; r < 3; r++) begin
      e = sb.pop_front();
      n_cmp++; if (rdata_a[r] !== e) begin n_mis++; $display("FAIL nobypass_new port%0d: got %h expected %h", r, rdata_a[r], e); end
      e = sb.pop_front();
      n_cmp++; if (rdata_e[r] !== e) begin n_mis++; $display("FAIL bypass_next port%0d: got %h expected %h", r, rdata_e[r], e); end
    end
    drv();
    we = 2'b11; waddr[0] = 5'd8; waddr[1] = 5'd8;
    wdata[0] = 32'h0BAD0000; wdata[1] = 32'h600D0001; raddr[0] = 5'd8;
    sb.push_back(ZA); sb.push_back(32'h600D0001);
    @(negedge clk);
    e = sb.pop_front();
    n_cmp++; if (rdata_a[0] !== e) begin n_mis++; $display("FAIL prio_old_a: got %h expected %h", rdata_a[0], e); end
    e = sb.pop_front();
    n_cmp++; if (rdata_e[0] !== e) begin n_mis++; $display("FAIL prio_bypass_e: got %h expected %h", rdata_e[0], e); end
    drv();
    we = '0;
    sb.push_back(32'h600D0001);
    @(negedge clk);
    e = sb.pop_front();
    n_cmp++; if (rdata_a[0] !== e) begin n_mis++; $display("FAIL prio_new_a: got %h expected %h", rdata_a[0], e); end
  endtask

  task automatic test_midrun_reset();
    logic [31:0] e;
    drv();
    we = 2'b01; waddr[0] = 5'd3; wdata[0] = 32'h00001234; raddr[0] = 5'd3; raddr[1] = 5'd4;
    drv();
    we = '0;
    sb.push_back(32'h00001234);
    @(negedge clk);
    e = sb.pop_front();
    n_cmp++; if (rdata_a[0] !== e) begin n_mis++; $display("FAIL pre_reset_a: got %h expected %h", rdata_a[0], e); end
    #2 rst_n = 1'b0;
    sb.push_back(32'd0); sb.push_back(32'd0); sb.push_back(ZA); sb.push_back(ZE);
    #1;
    e = sb.pop_front();
    n_cmp++; if ({31'd0, ready_a} !== e) begin n_mis++; $display("FAIL midrst_ready_a: got %b expected %h", ready_a, e); end
    e = sb.pop_front();
    n_cmp++; if ({31'd0, ready_e} !== e) begin n_mis++; $display("FAIL midrst_ready_e: got %b expected %h", ready_e, e); end
    e = sb.pop_front();
    n_cmp++; if (rdata_a[0] !== e) begin n_mis++; $display("FAIL init_read_a: got %h expected %h", rdata_a[0], e); end
    e = sb.pop_front();
    n_cmp++; if (rdata_e[0] !== e) begin n_mis++; $display("FAIL init_read_e: got %h expected %h", rdata_e[0], e); end
    drv();
    rst_n = 1'b1;
    drv(); drv();
    we = 2'b01; waddr[0] = 5'd4; wdata[0] = 32'h00005678;
    drv();
    we = '0;
    for (int i = 0; i < 100 && ready_a !== 1'b1; i++) @(negedge clk);
    sb.push_back(32'd1);
    e = sb.pop_front();
    n_cmp++; if ({31'd0, ready_a} !== e) begin n_mis++; $display("FAIL resweep_timeout: got %b expected %h", ready_a, e); end
    sb.push_back(ZA); sb.push_back(ZA); sb.push_back(ZE); sb.push_back(ZE);
    @(negedge clk);
    for (int r = 0; r < 2; r++) begin
      e = sb.pop_front();
      n_cmp++; if (rdata_a[r] !== e) begin n_mis++; $display("FAIL resweep_a addr%0d: got %h expected %h", 3 + r, rdata_a[r], e); end
    end
    for (int r = 0; r < 2; r++) begin
      e = sb.pop_front();
      n_cmp++; if (rdata_e[r] !== e) begin n_mis++; $display("FAIL resweep_e addr%0d: got %h expected %h", 3 + r, rdata_e[r], e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  a0, a1, pa0, pa1, ra;
    logic [31:0] d0, d1, xa, xe, e;
    logic [1:0]  w;
    for (int i = 0; i < 32; i++) m_a[i] = ZA;
    for (int i = 0; i < 16; i++) m_e[i] = ZE;
    pa0 = 5'd1; pa1 = 5'd2;
    for (int it = 0; it < 40; it++) begin
      drv();
      a0 = 5'($urandom_range(1, 15));
      a1 = ($urandom_range(0, 3) == 0) ? a0 : 5'($urandom_range(1, 15));
      d0 = $urandom; d1 = $urandom;
      w  = 2'($urandom_range(1, 3));
      we = w; waddr[0] = a0; waddr[1] = a1; wdata[0] = d0; wdata[1] = d1;
      raddr[0] = pa0; raddr[1] = pa1; raddr[2] = 5'($urandom_range(0, 15));
      for (int r = 0; r < 3; r++) begin
        ra = raddr[r];
        xa = (ra == 0) ? 32'd0 : m_a[ra];
        xe = (ra == 0) ? 32'd0 : m_e[ra[3:0]];
        if (ra != 0 && w[1] && a1 == ra) xe = d1;
        else if (ra != 0 && w[0] && a0 == ra) xe = d0;
        sb.push_back(xa); sb.push_back(xe);
      end
      sb.push_back(32'd0);
      @(negedge clk);
      for (int r = 0; r < 3; r++) begin
        e = sb.pop_front();
        n_cmp++; if (rdata_a[r] !== e) begin n_mis++; $display("FAIL b2b_a it%0d port%0d: got %h expected %h", it, r, rdata_a[r], e); end
        e = sb.pop_front();
        n_cmp++; if (rdata_e[r] !== e) begin n_mis++; $display("FAIL b2b_e it%0d port%0d: got %h expected %h", it, r, rdata_e[r], e); end
      end
      e = sb.pop_front();
      n_cmp++; if ({31'd0, err_a} !== e) begin n_mis++; $display("FAIL b2b_err it%0d: got %b expected %h", it, err_a, e); end
      if (w[0]) begin m_a[a0] = d0; m_e[a0[3:0]] = d0; end
      if (w[1]) begin m_a[a1] = d1; m_e[a1[3:0]] = d1; end
      pa0 = a0; pa1 = a1;
    end
    drv();
    we = '0;
  endtask

  task automatic test_wren();
    logic [31:0] e;
    drv();
    we = '0; waddr = '0;
    force dut_a.w_bank_we = 2'b10;
    sb.push_back(32'd1);
    @(negedge clk);
    e = sb.pop_front();
    n_cmp++; if ({31'd0, err_a} !== e) begin n_mis++; $display("FAIL wren_forced: got %b expected %h", err_a, e); end
    drv();
    release dut_a.w_bank_we;
    sb.push_back(32'd0);
    @(negedge clk);
    e = sb.pop_front();
    n_cmp++; if ({31'd0, err_a} !== e) begin n_mis++; $display("FAIL wren_released: got %b expected %h", err_a, e); end
  endtask

  initial begin
    test_en = 1'b0;
    test_reset();
    test_dual_write();
    test_r0_write();
    test_bypass();
    test_midrun_reset();
    test_back_to_back();
    test_wren();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
